// File: rtl/img_sram_arbiter.sv
// Image SRAM arbiter: host first, then urgent writeback, else round-robin
// between the fetch engine and a small writeback FIFO. One access per cycle.
module img_sram_arbiter #(
  parameter int ADDR_W      = 14,
  parameter int DATA_W      = 32,
  parameter int WFIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              host_req,
  input  logic              host_web,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_di,
  output logic              host_gnt,
  output logic              host_rvalid,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_gnt,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              wb_empty,
  output logic              wb_overflow,
  output logic              sram_ceb,
  output logic              sram_web,
  output logic [ADDR_W-1:0] sram_a,
  output logic [DATA_W-1:0] sram_di,
  input  logic [DATA_W-1:0] sram_do
);

  localparam int PTR_W = $clog2(WFIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    TAG_NONE  = 2'b00,
    TAG_FETCH = 2'b01,
    TAG_HOST  = 2'b10
  } tag_e;

  logic [ADDR_W-1:0] fifo_addr_mem [WFIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_mem [WFIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic              rr_wb_reg, rr_wb_next;
  tag_e              tag_reg, tag_next;
  logic              wb_empty_reg;
  logic              wb_overflow_reg;

  logic fifo_ne, fifo_full, urgent;
  logic wb_gnt, rr_grant, push_acc, overflow_set;

  assign fifo_ne   = (count_reg != '0);
  assign fifo_full = (count_reg == CNT_W'(WFIFO_DEPTH));
  assign urgent    = (count_reg >= CNT_W'(WFIFO_DEPTH - 1));

  // Grants are suppressed while reset is held so the SRAM pins stay idle.
  always_comb begin
    host_gnt = 1'b0;
    rd_gnt   = 1'b0;
    wb_gnt   = 1'b0;
    rr_grant = 1'b0;
    if (rst) begin
      if (host_req) begin
        host_gnt = 1'b1;
      end else if (urgent) begin
        wb_gnt = 1'b1;
      end else if (rd_req && fifo_ne) begin
        rr_grant = 1'b1;
        if (rr_wb_reg) wb_gnt = 1'b1;
        else           rd_gnt = 1'b1;
      end else if (rd_req) begin
        rr_grant = 1'b1;
        rd_gnt   = 1'b1;
      end else if (fifo_ne) begin
        rr_grant = 1'b1;
        wb_gnt   = 1'b1;
      end
    end
  end

  always_comb begin
    sram_ceb = 1'b1;
    sram_web = 1'b1;
    sram_a   = '0;
    sram_di  = '0;
    if (host_gnt) begin
      sram_ceb = 1'b0;
      sram_web = host_web;
      sram_a   = host_addr;
      sram_di  = host_web ? '0 : host_di;
    end else if (rd_gnt) begin
      sram_ceb = 1'b0;
      sram_a   = rd_addr;
    end else if (wb_gnt) begin
      sram_ceb = 1'b0;
      sram_web = 1'b0;
      sram_a   = fifo_addr_mem[rd_ptr_reg];
      sram_di  = fifo_data_mem[rd_ptr_reg];
    end
  end

  // A full FIFO still accepts a push when its head pops the same cycle.
  assign push_acc     = wb_valid && (!fifo_full || wb_gnt);
  assign overflow_set = wb_valid && fifo_full && !wb_gnt;

  always_comb begin
    count_next = count_reg;
    case ({push_acc, wb_gnt})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  always_comb begin
    rr_wb_next = rr_wb_reg;
    if (rr_grant) rr_wb_next = rd_gnt;
    tag_next = TAG_NONE;
    if (host_gnt && host_web) tag_next = TAG_HOST;
    else if (rd_gnt)          tag_next = TAG_FETCH;
  end

  always_ff @(posedge clk) begin
    if (push_acc) begin
      fifo_addr_mem[wr_ptr_reg] <= wb_addr;
      fifo_data_mem[wr_ptr_reg] <= wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      count_reg       <= '0;
      rr_wb_reg       <= 1'b0;
      tag_reg         <= TAG_NONE;
      wb_empty_reg    <= 1'b1;
      wb_overflow_reg <= 1'b0;
    end else begin
      if (push_acc) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (wb_gnt)   rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      count_reg       <= count_next;
      rr_wb_reg       <= rr_wb_next;
      tag_reg         <= tag_next;
      wb_empty_reg    <= (count_next == '0);
      wb_overflow_reg <= wb_overflow_reg | overflow_set;
    end
  end

  assign rd_valid    = (tag_reg == TAG_FETCH);
  assign host_rvalid = (tag_reg == TAG_HOST);
  assign rd_data     = (tag_reg != TAG_NONE) ? sram_do : '0;
  assign wb_empty    = wb_empty_reg;
  assign wb_overflow = wb_overflow_reg;

endmodule
